// File: rtl/controle_busca_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package controle_busca_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // Program lengths of the ROM images in use
    localparam int PROG_LEN_ALGORITMO_BASE = 35;
    localparam int PROG_LEN_FIBONACCI      = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/controle_busca_if.sv
// Fetch-unit bus: ROM address/data, instruction register handshake, redirect and status.
interface controle_busca_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] position;
    logic [DATA_W-1:0] instruction;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_target;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, instruction, ir_ready, branch_valid, branch_target,
        output position, ir, ir_pc, ir_valid, busy, done, err
    );

    modport slave (
        output start, instruction, ir_ready, branch_valid, branch_target,
        input  position, ir, ir_pc, ir_valid, busy, done, err
    );
endinterface

// File: rtl/controle_busca.sv
// Instruction-fetch sequencer: owns the pc, addresses a combinational ROM and
// presents each fetched word in a valid/ready instruction register.
module controle_busca
    import controle_busca_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PROG_LEN = PROG_LEN_ALGORITMO_BASE,
    parameter int RESET_PC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    controle_busca_if.master bus
);

    // One extra pc bit so a full 2**ADDR_W program ends without wrapping to 0
    localparam int              PC_W   = ADDR_W + 1;
    localparam logic [PC_W-1:0] END_PC = PC_W'(PROG_LEN);
    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic              err_q, err_d;

    logic in_fetch, fetching, xfer, load, restart, bad_target;

    assign in_fetch   = (state_q == ST_FETCH);
    assign fetching   = (pc_q < END_PC);
    assign xfer       = ir_valid_q & bus.ir_ready;
    assign load       = in_fetch & fetching & (!ir_valid_q | bus.ir_ready);
    assign restart    = bus.start & !in_fetch;
    assign bad_target = ({1'b0, bus.branch_target} >= END_PC);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (bus.start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.branch_valid) begin
                    if (bad_target) state_d = ST_DONE;
                end else if (xfer && !fetching) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus.busy = in_fetch;
        bus.done = (state_q == ST_DONE);
    end

    // Datapath: a redirect beats both load and stall
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        err_d      = err_q;
        if (restart) begin
            pc_d       = PC_RST;
            ir_valid_d = 1'b0;
            err_d      = 1'b0;
        end else if (in_fetch) begin
            if (bus.branch_valid) begin
                ir_valid_d = 1'b0;
                if (bad_target) err_d = 1'b1;
                else            pc_d  = {1'b0, bus.branch_target};
            end else if (load) begin
                ir_d       = bus.instruction;
                ir_pc_d    = pc_q[ADDR_W-1:0];
                ir_valid_d = 1'b1;
                pc_d       = pc_q + PC_W'(1);
            end else if (xfer) begin
                ir_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= PC_RST;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.position = pc_q[ADDR_W-1:0];
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.err      = err_q;

endmodule
